// File: rtl/membus_pkg.sv
// Shared definitions for the PDP-6 memory bus initiator: word/address widths,
// cycle-sequencer states and default timing constants.
package membus_pkg;

    localparam int WORD_W  = 36;
    localparam int ADDR_W  = 18;
    localparam int ADDR_LO = WORD_W - ADDR_W;
    localparam int CNT_W   = 8;

    localparam int DEF_DATA_DLY  = 3;
    localparam int DEF_DATA_HOLD = 2;
    localparam int DEF_TIMEOUT   = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_WAIT_RD,
        ST_RMW_WAIT,
        ST_WR_DLY,
        ST_WR_DATA,
        ST_WR_RS,
        ST_DONE
    } state_t;

    // Fast memory answers the first 16 words only, and only when enabled.
    function automatic logic fmc_hit(input logic [0:13] addr_hi, input logic fm_en);
        return fm_en && (addr_hi == '0);
    endfunction

endpackage

// File: rtl/membus_nxm_timer.sv
// Nonexistent-memory watchdog: restarts on load, counts while run is high and
// flags expiry on the TIMEOUT-th cycle of a wait.
module membus_nxm_timer
    import membus_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (run_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/membus_initiator.sv
// PDP-6 memory bus master: turns a one-shot read/write/RMW command into a full
// membus cycle. Define MEMBUS_TIMEOUT_EN to enable NXM detection by timeout.
module membus_initiator
    import membus_pkg::*;
#(
    parameter int DATA_DLY  = DEF_DATA_DLY,
    parameter int DATA_HOLD = DEF_DATA_HOLD
`ifdef MEMBUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = DEF_TIMEOUT
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    input  logic                    cmd_rd,
    input  logic                    cmd_wr,
    input  logic [ADDR_LO:WORD_W-1] cmd_addr,
    input  logic [0:WORD_W-1]       cmd_wdata,
    input  logic                    fm_enable,
    output logic                    busy,
    output logic [0:WORD_W-1]       rdata,
    output logic                    rdata_valid,
    input  logic [0:WORD_W-1]       rmw_wdata,
    input  logic                    rmw_valid,
    output logic                    done,
    output logic                    nxm,
    output logic                    membus_rq_cyc,
    output logic                    membus_rd_rq,
    output logic                    membus_wr_rq,
    output logic [21:35]            membus_ma,
    output logic [18:21]            membus_sel,
    output logic                    membus_fmc_select,
    output logic [0:WORD_W-1]       membus_mb_out,
    output logic                    membus_wr_rs,
    input  logic                    membus_addr_ack,
    input  logic                    membus_rd_rs,
    input  logic [0:WORD_W-1]       membus_mb_in
);

    localparam logic [CNT_W-1:0] DLY_LOAD  = CNT_W'(DATA_DLY - 2);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(DATA_HOLD - 1);

    state_t                  state_q, state_d;
    logic                    rd_q, rd_d, wr_q, wr_d, fmc_q, fmc_d;
    logic                    seen_q, seen_d, rvalid_q, rvalid_d;
    logic [ADDR_LO:WORD_W-1] addr_q, addr_d;
    logic [0:WORD_W-1]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    start_wr, tmo_hit, tmo_expired, active;

`ifdef MEMBUS_TIMEOUT_EN
    logic nxm_q, nxm_d;
    logic timer_load, timer_run;

    assign timer_load = (state_d != state_q);
    assign timer_run  = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_RD && !seen_q);

    membus_nxm_timer #(.TIMEOUT(TIMEOUT)) u_nxm_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (timer_load),
        .run_i     (timer_run),
        .expired_o (tmo_expired)
    );
    assign nxm = nxm_q;
`else
    assign tmo_expired = 1'b0;
    assign nxm         = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        fmc_d    = fmc_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        seen_d   = seen_q;
        rvalid_d = 1'b0;
        cnt_d    = cnt_q;
        start_wr = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && (cmd_rd || cmd_wr)) begin
                    rd_d    = cmd_rd;
                    wr_d    = cmd_wr;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    fmc_d   = fmc_hit(cmd_addr[18:31], fm_enable);
                    rdata_d = '0;
                    seen_d  = 1'b0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (membus_addr_ack) begin
                    if (rd_q) begin
                        state_d = ST_WAIT_RD;
                    end else begin
                        start_wr = 1'b1;
                    end
                end else if (tmo_expired) begin
                    tmo_hit = 1'b1;
                end
            end
            // Keep ORing one cycle past rd_rs: slow responders settle late.
            ST_WAIT_RD: begin
                if (membus_rd_rs) begin
                    rdata_d = rdata_q | membus_mb_in;
                    seen_d  = 1'b1;
                end else if (seen_q) begin
                    rdata_d  = rdata_q | membus_mb_in;
                    rvalid_d = 1'b1;
                    state_d  = wr_q ? ST_RMW_WAIT : ST_DONE;
                end else if (tmo_expired) begin
                    tmo_hit = 1'b1;
                end
            end
            ST_RMW_WAIT: begin
                if (rmw_valid) begin
                    wdata_d  = rmw_wdata;
                    start_wr = 1'b1;
                end
            end
            ST_WR_DLY: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_DATA;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR_DATA: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_RS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR_RS: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // The ack/rmw_valid cycle itself counts as the first cycle of the delay.
        if (start_wr) begin
            if (DATA_DLY > 1) begin
                state_d = ST_WR_DLY;
                cnt_d   = DLY_LOAD;
            end else begin
                state_d = ST_WR_DATA;
                cnt_d   = HOLD_LOAD;
            end
        end
        if (tmo_hit) begin
            state_d = ST_DONE;
            rdata_d = '0;
        end
    end

`ifdef MEMBUS_TIMEOUT_EN
    assign nxm_d = tmo_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nxm_q <= 1'b0;
        end else begin
            nxm_q <= nxm_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            fmc_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            seen_q   <= 1'b0;
            rvalid_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            fmc_q    <= fmc_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            seen_q   <= seen_d;
            rvalid_q <= rvalid_d;
            cnt_q    <= cnt_d;
        end
    end

    // All bus lines decode from registered state so reset drops them at once.
    assign active = (state_q != ST_IDLE) && (state_q != ST_DONE);

    assign busy              = active;
    assign done              = (state_q == ST_DONE);
    assign rdata             = rdata_q;
    assign rdata_valid       = rvalid_q;
    assign membus_rq_cyc     = (state_q == ST_WAIT_ACK);
    assign membus_rd_rq      = rd_q && ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_RD));
    assign membus_wr_rq      = wr_q && ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_RD) ||
                                        (state_q == ST_RMW_WAIT) || (state_q == ST_WR_DLY) ||
                                        (state_q == ST_WR_DATA));
    assign membus_ma         = active ? addr_q[21:35] : '0;
    assign membus_sel        = active ? addr_q[18:21] : '0;
    assign membus_fmc_select = active && fmc_q;
    assign membus_mb_out     = (state_q == ST_WR_DATA) ? wdata_q : '0;
    assign membus_wr_rs      = (state_q == ST_WR_RS);

endmodule

// File: tb/tb_membus_initiator.sv
// Self-checking bench for membus_initiator: directed and random bus cycles
// against a cycle-timing model of the membus protocol held in the bench.
module tb_membus_initiator;

    localparam int DATA_DLY  = 3;
    localparam int DATA_HOLD = 2;
    localparam int TIMEOUT   = 255;
    localparam int BUDGET    = 400;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0, cmd_rd = 1'b0, cmd_wr = 1'b0;
    logic [18:35] cmd_addr = '0;
    logic [0:35]  cmd_wdata = '0;
    logic         fm_enable = 1'b0;
    logic         busy;
    logic [0:35]  rdata;
    logic         rdata_valid;
    logic [0:35]  rmw_wdata = '0;
    logic         rmw_valid = 1'b0;
    logic         done, nxm;
    logic         membus_rq_cyc, membus_rd_rq, membus_wr_rq;
    logic [21:35] membus_ma;
    logic [18:21] membus_sel;
    logic         membus_fmc_select;
    logic [0:35]  membus_mb_out;
    logic         membus_wr_rs;
    logic         membus_addr_ack = 1'b0;
    logic         membus_rd_rs = 1'b0;
    logic [0:35]  membus_mb_in = '0;

    logic [0:35]  rs_words [8];
    logic [0:35]  tail_word;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    membus_initiator dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_rd            (cmd_rd),
        .cmd_wr            (cmd_wr),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .fm_enable         (fm_enable),
        .busy              (busy),
        .rdata             (rdata),
        .rdata_valid       (rdata_valid),
        .rmw_wdata         (rmw_wdata),
        .rmw_valid         (rmw_valid),
        .done              (done),
        .nxm               (nxm),
        .membus_rq_cyc     (membus_rq_cyc),
        .membus_rd_rq      (membus_rd_rq),
        .membus_wr_rq      (membus_wr_rq),
        .membus_ma         (membus_ma),
        .membus_sel        (membus_sel),
        .membus_fmc_select (membus_fmc_select),
        .membus_mb_out     (membus_mb_out),
        .membus_wr_rs      (membus_wr_rs),
        .membus_addr_ack   (membus_addr_ack),
        .membus_rd_rs      (membus_rd_rs),
        .membus_mb_in      (membus_mb_in)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:35] rand_word();
        return 36'({$urandom(), $urandom()});
    endfunction

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_wr = 1'b0;
        membus_addr_ack = 1'b0; membus_rd_rs = 1'b0; membus_mb_in = '0;
        rmw_valid = 1'b0; rmw_wdata = '0;
    endtask

    // One complete bus cycle. The bench plays the responder and predicts every
    // timing point from the protocol rules (ack cycle, rd_rs window, rmw_valid).
    task automatic run_txn(input string name, input bit rd, input bit wr,
                           input logic [18:35] addr, input logic [0:35] wdata, input bit fm,
                           input int ack_dly, input int rs_gap, input int n_rs,
                           input int rmw_dly, input logic [0:35] rmw_data);
        logic [0:35] exp_rdata, wr_data, exp_mb, rdata_at_rv;
        int a, f, rv, r, s, done_n, rv_cnt, rs_cnt, rs_n, mb_first, mb_bad, overlap;
        logic nxm_at_done, busy_at_done;
        a = -1; f = -1; rv = -1; r = -1; s = -1; done_n = -1;
        rv_cnt = 0; rs_cnt = 0; rs_n = -1; mb_first = -1; mb_bad = 0; overlap = 0;
        nxm_at_done = 1'b0; busy_at_done = 1'b1; rdata_at_rv = '0;
        wr_data = (rd && wr) ? rmw_data : wdata;
        exp_rdata = tail_word;
        for (int i = 0; i < n_rs; i++) exp_rdata |= rs_words[i];

        @(negedge clk);
        cmd_valid = 1'b1; cmd_rd = rd; cmd_wr = wr; cmd_addr = addr;
        cmd_wdata = wdata; fm_enable = fm;
        for (int n = 1; n <= BUDGET && done_n < 0; n++) begin
            @(negedge clk);
            cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_wr = 1'b0;
            if (n == 1) begin
                check_value({name, ".busy"},   64'(busy), 64'(1));
                check_value({name, ".rq_cyc"}, 64'(membus_rq_cyc), 64'(1));
                check_value({name, ".rd_rq"},  64'(membus_rd_rq), 64'(rd));
                check_value({name, ".wr_rq"},  64'(membus_wr_rq), 64'(wr));
                check_value({name, ".ma"},     64'(membus_ma), 64'(addr[21:35]));
                check_value({name, ".sel"},    64'(membus_sel), 64'(addr[18:21]));
                check_value({name, ".fmc"},    64'(membus_fmc_select),
                            64'(fm && addr <= 18'd15));
                check_value({name, ".rdata_clr"}, 64'(rdata), 64'(0));
            end
            if (a >= 0 && n == a + 1)
                check_value({name, ".rq_cyc_drop"}, 64'(membus_rq_cyc), 64'(0));
            if (rdata_valid) begin rv_cnt++; rv = n; rdata_at_rv = rdata; end
            if (membus_wr_rs) begin rs_cnt++; rs_n = n; end
            if (wr) s = rd ? r : a;
            exp_mb = (s >= 0 && n >= s + DATA_DLY && n < s + DATA_DLY + DATA_HOLD) ? wr_data : '0;
            if (membus_mb_out !== exp_mb) mb_bad++;
            if (membus_mb_out != '0 && mb_first < 0) mb_first = n;
            if (membus_mb_out != '0 && membus_rd_rq) overlap++;
            if (done) begin done_n = n; nxm_at_done = nxm; busy_at_done = busy; end

            membus_addr_ack = 1'b0; membus_rd_rs = 1'b0; membus_mb_in = '0;
            rmw_valid = 1'b0; rmw_wdata = '0;
            if (a < 0 && n == ack_dly) begin
                membus_addr_ack = 1'b1; a = n;
                if (rd) f = a + 1 + rs_gap;
            end
            if (f >= 0 && n >= f && n < f + n_rs) begin
                membus_rd_rs = 1'b1; membus_mb_in = rs_words[n - f];
            end else if (f >= 0 && n == f + n_rs) begin
                membus_mb_in = tail_word;
            end
            if (rd && wr && rv >= 0 && r < 0 && n == rv + rmw_dly) begin
                rmw_valid = 1'b1; rmw_wdata = rmw_data; r = n;
            end
        end
        idle_inputs();

        check_value({name, ".done_seen"}, 64'(done_n >= 0), 64'(1));
        if (done_n >= 0) begin
            check_value({name, ".done_cycle"}, 64'(done_n),
                        64'(wr ? s + DATA_DLY + DATA_HOLD + 1 : f + n_rs + 1));
            check_value({name, ".nxm"}, 64'(nxm_at_done), 64'(0));
            check_value({name, ".busy_at_done"}, 64'(busy_at_done), 64'(0));
            check_value({name, ".mb_out"}, 64'(mb_bad), 64'(0));
            if (rd) begin
                check_value({name, ".rvalid_cnt"}, 64'(rv_cnt), 64'(1));
                check_value({name, ".rvalid_cycle"}, 64'(rv), 64'(f + n_rs + 1));
                check_value({name, ".rdata"}, 64'(rdata_at_rv), 64'(exp_rdata));
            end else begin
                check_value({name, ".rvalid_cnt"}, 64'(rv_cnt), 64'(0));
            end
            if (wr) begin
                check_value({name, ".mb_first"}, 64'(mb_first),
                            (wr_data == '0) ? 64'(-1) : 64'(s + DATA_DLY));
                check_value({name, ".wr_rs_cnt"}, 64'(rs_cnt), 64'(1));
                check_value({name, ".wr_rs_cycle"}, 64'(rs_n), 64'(s + DATA_DLY + DATA_HOLD));
                check_value({name, ".rd_rq_overlap"}, 64'(overlap), 64'(0));
            end else begin
                check_value({name, ".wr_rs_cnt"}, 64'(rs_cnt), 64'(0));
            end
        end
        $display("txn %s rd=%0d wr=%0d addr=%o done_at=%0d rdata=%o", name, rd, wr, addr,
                 done_n, rdata_at_rv);
    endtask

    task automatic reset_mid_write();
        int found;
        found = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 18'o000007;
        cmd_wdata = 36'o525252525252; fm_enable = 1'b0;
        @(negedge clk);
        idle_inputs();
        membus_addr_ack = 1'b1;
        @(negedge clk);
        membus_addr_ack = 1'b0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            if (membus_mb_out != '0) found = 1;
            else @(negedge clk);
        end
        check_value("rst.reach_wr_data", 64'(found), 64'(1));
        #2 reset = 1'b1;
        #1;
        check_value("rst.mb_out_async", 64'(membus_mb_out), 64'(0));
        check_value("rst.wr_rq_async", 64'(membus_wr_rq), 64'(0));
        check_value("rst.busy_async", 64'(busy), 64'(0));
        @(negedge clk);
        check_value("rst.no_wr_rs", 64'(membus_wr_rs), 64'(0));
        reset = 1'b0;
        $display("txn reset_mid_write reached_wr_data=%0d", found);
    endtask

    task automatic ignored_events();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 18'o000042;
        @(negedge clk);
        cmd_valid = 1'b0;
        membus_addr_ack = 1'b1; membus_rd_rs = 1'b1; membus_mb_in = 36'o777777777777;
        @(negedge clk);
        check_value("ign.busy_no_rw", 64'(busy), 64'(0));
        idle_inputs();
        @(negedge clk);
        check_value("ign.rq_cyc", 64'(membus_rq_cyc), 64'(0));
        check_value("ign.rdata_valid", 64'(rdata_valid), 64'(0));
        check_value("ign.busy_ack", 64'(busy), 64'(0));
        $display("txn ignored_events busy=%0d", busy);
    endtask

`ifdef MEMBUS_TIMEOUT_EN
    task automatic run_timeout();
        int done_n, rs_cnt;
        logic nxm_v, bus_v;
        logic [0:35] rdata_v;
        done_n = -1; rs_cnt = 0; nxm_v = 1'b0; bus_v = 1'b1; rdata_v = '1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 18'o070000;
        for (int n = 1; n <= TIMEOUT + 10 && done_n < 0; n++) begin
            @(negedge clk);
            idle_inputs();
            if (membus_wr_rs) rs_cnt++;
            if (done) begin
                done_n = n; nxm_v = nxm; rdata_v = rdata;
                bus_v = membus_rq_cyc | membus_rd_rq | membus_wr_rq | (membus_mb_out != '0);
            end
        end
        check_value("tmo.done_cycle", 64'(done_n), 64'(TIMEOUT + 1));
        check_value("tmo.nxm", 64'(nxm_v), 64'(1));
        check_value("tmo.rdata", 64'(rdata_v), 64'(0));
        check_value("tmo.bus_idle", 64'(bus_v), 64'(0));
        check_value("tmo.no_wr_rs", 64'(rs_cnt), 64'(0));
        $display("txn timeout done_at=%0d nxm=%0d", done_n, nxm_v);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:35] x;
        tail_word = '0;
        for (int i = 0; i < 8; i++) rs_words[i] = '0;

        @(negedge clk);
        @(negedge clk);
        check_value("reset.busy", 64'(busy), 64'(0));
        check_value("reset.done_nxm", 64'({done, nxm, rdata_valid}), 64'(0));
        check_value("reset.rdata", 64'(rdata), 64'(0));
        check_value("reset.bus_req", 64'({membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs}), 64'(0));
        check_value("reset.bus_addr", 64'({membus_ma, membus_sel, membus_fmc_select}), 64'(0));
        check_value("reset.mb_out", 64'(membus_mb_out), 64'(0));
        reset = 1'b0;

        rs_words[0] = 36'o123456701234; rs_words[1] = 36'o123456701234; tail_word = '0;
        run_txn("read123", 1'b1, 1'b0, 18'o000123, '0, 1'b0, 4, 0, 2, 0, '0);

        run_txn("write5", 1'b0, 1'b1, 18'o000005, 36'o777000777000, 1'b1, 2, 0, 0, 0, '0);

        x = rand_word();
        rs_words[0] = x; tail_word = '0;
        run_txn("rmw40000", 1'b1, 1'b1, 18'o040000, '0, 1'b0, 3, 1, 1, 3, x + 36'd1);

        rs_words[0] = 36'o1; tail_word = 36'o2;
        run_txn("or_tail", 1'b1, 1'b0, 18'o000017, '0, 1'b1, 1, 0, 1, 0, '0);
        rs_words[0] = 36'o1; rs_words[1] = 36'o2; tail_word = '0;
        run_txn("or_window", 1'b1, 1'b0, 18'o000020, '0, 1'b1, 2, 2, 2, 0, '0);

        ignored_events();
        reset_mid_write();
        rs_words[0] = 36'o000000000777; tail_word = 36'o777000000000;
        run_txn("read_after_rst", 1'b1, 1'b0, 18'o001234, '0, 1'b0, 2, 0, 1, 0, '0);

        for (int t = 0; t < 24; t++) begin
            int kind;
            logic [18:35] addr;
            kind = int'($urandom_range(0, 2));
            addr = ($urandom_range(0, 3) == 0) ? 18'($urandom_range(0, 15)) : 18'($urandom());
            for (int i = 0; i < 8; i++) rs_words[i] = rand_word();
            tail_word = ($urandom_range(0, 1) == 1) ? rand_word() : '0;
            run_txn($sformatf("rnd%0d", t), kind != 1, kind != 0, addr, rand_word(),
                    1'($urandom_range(0, 1)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                    int'($urandom_range(0, 4)), rand_word());
        end

`ifdef MEMBUS_TIMEOUT_EN
        run_timeout();
        rs_words[0] = 36'o42; tail_word = '0;
        run_txn("read_after_tmo", 1'b1, 1'b0, 18'o000044, '0, 1'b0, 1, 0, 1, 0, '0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/membus_initiator.md
Name: membus_initiator

Overview:
- Processor-side master for the PDP-6 memory bus.
- Converts a one-shot client command (read, write or read-modify-write) into a full membus cycle: request, address acknowledge, read restart/strobe, write data and write restart.
- Sits between a CPU/console datapath and one membus port of a core memory or fast-memory responder.
- Detects nonexistent memory by timeout.

Parameters:
DATA_DLY, 3, cycles from addr_ack to first driving of membus_mb_out on writes (responder cell-clear window)
DATA_HOLD, 2, cycles membus_mb_out is held with write data
TIMEOUT, 255, cycles to wait for addr_ack or rd_rs before declaring NXM (8-bit counter)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cmd_valid  in  1  start command (sampled in IDLE only)
cmd_rd  in  1  read phase requested
cmd_wr  in  1  write phase requested (rd&wr = read-modify-write)
cmd_addr  in  [18:35]  word address
cmd_wdata  in  [0:35]  write data for plain write
fm_enable  in  1  allow fast-memory select for addresses 0-15
busy  out  1  cycle in progress
rdata  out  [0:35]  read data (OR-accumulated)
rdata_valid  out  1  one-cycle pulse when rdata is final
rmw_wdata  in  [0:35]  write data for the RMW write half
rmw_valid  in  1  client supplies rmw_wdata (sampled in RMW_WAIT)
done  out  1  one-cycle pulse, cycle complete
nxm  out  1  one-cycle pulse with done on timeout
membus_rq_cyc  out  1  cycle request
membus_rd_rq  out  1  read request
membus_wr_rq  out  1  write request
membus_ma  out  [21:35]  = cmd_addr[21:35] (latched)
membus_sel  out  [18:21]  = cmd_addr[18:21] (latched)
membus_fmc_select  out  1  fm_enable & cmd_addr[18:31]==0 (latched)
membus_mb_out  out  [0:35]  write data; zero otherwise
membus_wr_rs  out  1  write restart pulse
membus_addr_ack  in  1  responder address acknowledge
membus_rd_rs  in  1  responder read restart
membus_mb_in  in  [0:35]  responder data (wired-OR)

Behaviour:
- Reset: state IDLE; every output 0; latched address, data and rdata cleared. Reset mid-cycle drops all bus lines immediately. No wr_rs is issued.
- Command latch: cmd_valid in IDLE with neither cmd_rd nor cmd_wr is ignored. Otherwise latch addr/wdata/rd/wr/fm-select. Next cycle assert rq_cyc, rd_rq if rd, wr_rq if wr, plus ma/sel/fmc_select; clear rdata; busy=1.
- States: IDLE, WAIT_ACK, WAIT_RD, RMW_WAIT, WR_DLY, WR_DATA, WR_RS, DONE.
- WAIT_ACK: on addr_ack high, drop rq_cyc the same edge; this prevents a retrigger. If rd, go to WAIT_RD; otherwise go to WR_DLY.
- WAIT_RD: each cycle rd_rs is high, rdata <= rdata | mb_in. Accumulation continues one cycle after rd_rs falls. Then pulse rdata_valid and drop rd_rq.
  - Read only: go to DONE.
  - RMW: go to RMW_WAIT.
- RMW_WAIT: hold wr_rq; on rmw_valid, latch rmw_wdata and go to WR_DLY. No timeout applies here.
- WR_DLY: count DATA_DLY cycles from addr_ack (RMW: from rmw_valid), then go to WR_DATA.
- WR_DATA: mb_out = latched data for DATA_HOLD cycles, then mb_out = 0 and go to WR_RS.
- WR_RS: wr_rs = 1 for one cycle; drop wr_rq the same cycle; go to DONE.
- DONE: done pulse one cycle, busy=0, then IDLE. Earliest new command is accepted the following cycle.
- rd_rq and wr_rq are never asserted without the latched command. mb_out is nonzero only in WR_DATA.
- addr_ack or rd_rs arriving in an unexpected state is ignored.

Optional Feature:
- Macro MEMBUS_TIMEOUT_EN.
- Defined: an 8-bit counter runs in WAIT_ACK and WAIT_RD and restarts on each state entry. On reaching TIMEOUT, all bus requests drop, mb_out=0, no wr_rs is issued, and the block goes to DONE with nxm=1 and rdata=0.
- Undefined: no counter; the block waits forever and nxm is tied 0.

Decomposition:
- Shared package membus_pkg: state encoding constants, address and word widths (18 and 36), default DATA_DLY/DATA_HOLD/TIMEOUT.
- One natural sub-module, membus_nxm_timer: load/count/expire. It is instantiated only under MEMBUS_TIMEOUT_EN.

Test Plan:
- Read addr 0o000123, fm_enable=0, responder acks after 4 cycles, rd_rs 2 cycles with mb_in=0o123456701234 -> rq_cyc drops on ack edge; rdata=0o123456701234; rdata_valid then done; fmc_select=0; sel=0, ma=0o123.
- Write addr 5, fm_enable=1, wdata=0o777000777000 -> fmc_select=1; mb_out=wdata exactly 2 cycles starting 3 cycles after ack; wr_rs one cycle after mb_out clears; done.
- RMW addr 0o040000 -> read returns X; rmw_valid with X+1 three cycles later -> write X+1, single wr_rs, rd_rq low before mb_out nonzero.
- OR accumulation: mb_in 0o1 then 0o2 across the rd_rs window -> rdata=0o3.
- MEMBUS_TIMEOUT_EN, no addr_ack -> after 255 cycles done=nxm=1, all bus outputs 0, no wr_rs.
- Async reset asserted in WR_DATA -> mb_out, wr_rq, busy go 0 without waiting for clk; a new read after reset completes normally.
